uart_frame_rx: RTL and testbench
================================

UART_FRAME_RX -- requirements
Module: uart_frame_rx

Interface
Parameters:
REQ-001 The block SHALL have parameter BIT_DIV, default 434: CLK_50M cycles per UART bit (115200 baud).
REQ-002 The block SHALL have parameter GAP_BITS, default 20: idle-line bit periods that force frame resynchronisation.

Ports (name, direction, width, meaning):
REQ-003 The block SHALL have port CLK_50M, input, 1: system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port RESET_n, input, 1: synchronous, active-low reset.
REQ-005 The block SHALL have port RX, input, 1: asynchronous UART line, idle high, 8N1, LSB first.
REQ-006 The block SHALL have port DATA_OUT, output, 256: channel n word at [16n+15:16n], n=0..15 (channel 0 = U10 … channel 15 = U25).
REQ-007 The block SHALL have port FRAME_VALID, output, 1: one-cycle pulse when DATA_OUT updates.
REQ-008 The block SHALL have port FRAME_ERR, output, 1: one-cycle pulse when a partial frame is discarded.
REQ-009 The block SHALL have port BYTE_VALID, output, 1: one-cycle pulse per accepted byte.
REQ-010 The block SHALL have port BYTE_DATA, output, 8: last accepted byte, held until the next one.
REQ-011 The block SHALL have port FRAME_CNT, output, 16: count of completed frames, wraps 0xFFFF->0.

Function
REQ-012 RX SHALL pass a 2-flop synchroniser (both flops reset to 1); all decisions use the synchronised value rxs.
REQ-013 The bit FSM SHALL have states IDLE, START, DATA, STOP.
- IDLE->START on rxs=0, bit counter cleared.
REQ-014 In START, at count BIT_DIV/2-1:
- rxs=0 -> DATA.
- rxs=1 -> IDLE (glitch rejected, no byte, no error).
REQ-015 In DATA, rxs SHALL be sampled every BIT_DIV cycles after mid-start, 8 samples, shifted LSB first; DATA->STOP after bit 7.
REQ-016 In STOP, rxs SHALL be sampled BIT_DIV cycles after bit 7, then the FSM returns to IDLE.
- rxs=1: BYTE_VALID=1 and BYTE_DATA=byte on the next cycle.
- rxs=0 (framing error): byte discarded; if byte index≠0, FRAME_ERR pulses; byte index -> 0.
REQ-017 Byte index SHALL run 0..31; frame layout is channel 0 low, channel 0 high, channel 1 low … channel 15 high.
REQ-018 On each accepted byte:
- Even index: byte latched as the pending low byte.
- Odd index: shadow[index/2] <= {byte, pending low}.
- Index then increments.
REQ-019 On acceptance of byte 31:
- The cycle after BYTE_VALID, all 16 shadow words SHALL copy to DATA_OUT simultaneously.
- FRAME_VALID pulses in that same cycle, FRAME_CNT increments, index wraps to 0.
- DATA_OUT never shows a mix of two frames.
REQ-020 Gap timer SHALL count cycles while the FSM is in IDLE and rxs=1, and clear on any other condition.
- On reaching GAP_BITS*BIT_DIV with index≠0: FRAME_ERR pulses, index -> 0, shadow unchanged, DATA_OUT unchanged.
- With index=0: no action; counter saturates.
REQ-021 A start edge in the same cycle as gap expiry SHALL take priority: timer clears, no resync, byte proceeds.
REQ-022 Latency SHALL be: stop-bit sample -> BYTE_VALID, 1 cycle; final BYTE_VALID -> FRAME_VALID/DATA_OUT, 1 cycle.
REQ-023 FRAME_VALID, FRAME_ERR and BYTE_VALID SHALL be mutually exclusive in any cycle.

Reset
REQ-024 While RESET_n=0 at a clock edge, the block SHALL reset as follows:
- FSM = IDLE; index, counters and gap timer = 0.
- DATA_OUT = 0, BYTE_DATA = 0, FRAME_CNT = 0.
- All pulse outputs = 0; synchroniser = 1.
REQ-025 Reset mid-byte or mid-frame SHALL discard the partial byte/frame with no FRAME_ERR pulse.
- First start bit after release begins byte index 0.

Verification
REQ-026 Full frame, channel n = 0x1100+n (low byte first) -> 32 BYTE_VALID pulses, then one FRAME_VALID, DATA_OUT[15:0]=0x1100, DATA_OUT[255:240]=0x110F, FRAME_CNT=1.
REQ-027 10 bytes, then line idle 20 bit times, then full frame of 0xA5A5 -> FRAME_ERR once at gap expiry, then FRAME_VALID with all channels 0xA5A5; DATA_OUT unchanged before that.
REQ-028 Byte 5 sent with stop bit 0 -> no BYTE_VALID for it, FRAME_ERR=1, index=0; next 32 good bytes form a valid frame.
REQ-029 RX low pulse of BIT_DIV/4 cycles -> no BYTE_VALID, no FRAME_ERR, FSM back to IDLE.
REQ-030 RESET_n=0 for 1 cycle after 17 bytes, then full frame -> no FRAME_ERR, one FRAME_VALID, FRAME_CNT=1.
REQ-031 65536 back-to-back frames -> FRAME_CNT wraps to 0; byte timing within ±1 cycle of BIT_DIV.

Source files
------------

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: 8N1 UART receiver that assembles 32-byte frames into 16 channel words
module uart_frame_rx #(
  parameter int BIT_DIV  = 434,
  parameter int GAP_BITS = 20
) (
  input  logic         CLK_50M,
  input  logic         RESET_n,
  input  logic         RX,
  output logic [255:0] DATA_OUT,
  output logic         FRAME_VALID,
  output logic         FRAME_ERR,
  output logic         BYTE_VALID,
  output logic [7:0]   BYTE_DATA,
  output logic [15:0]  FRAME_CNT
);
  localparam int CW      = $clog2(BIT_DIV);
  localparam int GAP_LIM = GAP_BITS * BIT_DIV;
  localparam int GW      = $clog2(GAP_LIM + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t         r_state, w_next;
  logic           r_rx_m, r_rxs;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_bit;
  logic [7:0]     r_sh, r_low;
  logic [4:0]     r_idx;
  logic [255:0]   r_shadow;
  logic           r_frame_pend;
  logic [GW-1:0]  r_gap;
  logic           w_half, w_full, w_accept, w_stop_bad, w_gap_run, w_gap_hit;
  // Bit FSM state register
  always_ff @(posedge CLK_50M)
    r_state <= !RESET_n ? IDLE : w_next;
  // Next-state logic and per-cycle strobes; a start bit that fails mid-bit sampling is a glitch
  always_comb begin
    w_next     = r_state;
    w_half     = r_cnt == CW'(BIT_DIV / 2 - 1);
    w_full     = r_cnt == CW'(BIT_DIV - 1);
    w_accept   = r_state == STOP && w_full && r_rxs;
    w_stop_bad = r_state == STOP && w_full && !r_rxs;
    w_gap_run  = r_state == IDLE && r_rxs;
    w_gap_hit  = w_gap_run && r_gap == GW'(GAP_LIM - 1);
    case (r_state)
      IDLE:    w_next = r_rxs ? IDLE : START;
      START:   w_next = w_half ? (r_rxs ? IDLE : DATA) : START;
      DATA:    w_next = (w_full && r_bit == 3'd7) ? STOP : DATA;
      default: w_next = w_full ? IDLE : STOP;
    endcase
  end
  // Synchroniser, bit timing, byte assembly, frame buffering and line-gap resync
  always_ff @(posedge CLK_50M) begin
    if (!RESET_n) begin
      r_rx_m       <= 1'b1;
      r_rxs        <= 1'b1;
      r_cnt        <= '0;
      r_bit        <= '0;
      r_sh         <= '0;
      r_low        <= '0;
      r_idx        <= '0;
      r_shadow     <= '0;
      r_frame_pend <= 1'b0;
      r_gap        <= '0;
      DATA_OUT     <= '0;
      FRAME_VALID  <= 1'b0;
      FRAME_ERR    <= 1'b0;
      BYTE_VALID   <= 1'b0;
      BYTE_DATA    <= '0;
      FRAME_CNT    <= '0;
    end else begin
      r_rx_m       <= RX;
      r_rxs        <= r_rx_m;
      r_cnt        <= (r_state == IDLE || (r_state == START && w_half) || w_full) ? '0 : r_cnt + 1'b1;
      if (r_state == DATA && w_full) begin
        r_sh  <= {r_rxs, r_sh[7:1]};
        r_bit <= r_bit + 1'b1;
      end
      BYTE_VALID   <= w_accept;
      if (w_accept)
        BYTE_DATA <= r_sh;
      r_frame_pend <= w_accept && r_idx == 5'd31;
      FRAME_VALID  <= r_frame_pend;
      if (r_frame_pend) begin
        DATA_OUT  <= r_shadow;
        FRAME_CNT <= FRAME_CNT + 1'b1;
      end
      FRAME_ERR    <= (w_stop_bad || w_gap_hit) && r_idx != 5'd0;
      r_gap        <= !w_gap_run ? '0 : (r_gap == GW'(GAP_LIM)) ? r_gap : r_gap + 1'b1;
      if (w_accept) begin
        if (!r_idx[0])
          r_low <= r_sh;
        else
          r_shadow[{r_idx[4:1], 4'b0} +: 16] <= {r_sh, r_low};
        r_idx <= r_idx + 1'b1;
      end else if (w_stop_bad || w_gap_hit)
        r_idx <= '0;
    end
  end
endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: scoreboard bench for uart_frame_rx with directed frames, gaps, framing errors and reset
module tb_uart_frame_rx;
  localparam int BD = 16;
  localparam int GB = 20;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         rx = 1'b1;
  logic [255:0] data_out;
  logic         frame_valid, frame_err, byte_valid;
  logic [7:0]   byte_data;
  logic [15:0]  frame_cnt;
  int           checks = 0;
  int           errors = 0;
  int           q_err = 0;
  logic [7:0]   q_byte[$];
  logic [271:0] q_frame[$];
  logic [255:0] exp_last = '0;
  logic [15:0]  exp_cnt = '0;
  logic [255:0] d;

  uart_frame_rx #(.BIT_DIV(BD), .GAP_BITS(GB)) dut (
    .CLK_50M(clk), .RESET_n(rst_n), .RX(rx), .DATA_OUT(data_out),
    .FRAME_VALID(frame_valid), .FRAME_ERR(frame_err), .BYTE_VALID(byte_valid),
    .BYTE_DATA(byte_data), .FRAME_CNT(frame_cnt)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [271:0] act, input logic [271:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [271:0] f;
    if (rst_n) begin
      if (byte_valid || frame_valid || frame_err)
        chk("exclusive", $countones({byte_valid, frame_valid, frame_err}), 1);
      if (byte_valid) begin
        chk("byte_expected", q_byte.size() != 0, 1);
        if (q_byte.size() != 0)
          chk("byte_data", byte_data, q_byte.pop_front());
        chk("data_hold_byte", data_out, exp_last);
      end
      if (frame_valid) begin
        chk("frame_expected", q_frame.size() != 0, 1);
        if (q_frame.size() != 0) begin
          f = q_frame.pop_front();
          chk("frame_data", data_out, f[255:0]);
          chk("frame_cnt", frame_cnt, f[271:256]);
          exp_last = f[255:0];
        end
      end
      if (frame_err) begin
        chk("err_expected", q_err > 0, 1);
        q_err--;
        chk("data_hold_err", data_out, exp_last);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk) rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BD) @(negedge clk);
    end
    rx = stop;
    repeat (BD) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic good(input logic [7:0] b);
    q_byte.push_back(b);
    send_byte(b, 1'b1);
  endtask

  task automatic frame(input logic [255:0] w);
    exp_cnt = exp_cnt + 16'd1;
    q_frame.push_back({exp_cnt, w});
    for (int n = 0; n < 16; n++) begin
      good(w[16*n +: 8]);
      good(w[16*n+8 +: 8]);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 4000 && (q_byte.size() != 0 || q_frame.size() != 0 || q_err != 0); i++)
      @(negedge clk);
    chk(name, q_byte.size() + q_frame.size() + q_err, 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 256'd0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    chk("rst_byte_data", byte_data, 8'd0);
    chk("rst_pulses", {frame_valid, frame_err, byte_valid}, 3'b000);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int n = 0; n < 16; n++) d[16*n +: 16] = 16'h1100 + 16'(n);
    frame(d);
    drain("drain_frame1");
    chk("f1_ch0", data_out[15:0], 16'h1100);
    chk("f1_ch15", data_out[255:240], 16'h110F);
    chk("f1_cnt", frame_cnt, 16'd1);

    for (int i = 0; i < 10; i++) good(8'h5A);
    q_err++;
    repeat (25 * BD) @(negedge clk);
    drain("drain_gap");
    chk("gap_hold_ch0", data_out[15:0], 16'h1100);
    frame({16{16'hA5A5}});
    drain("drain_frame2");
    chk("f2_cnt", frame_cnt, 16'd2);

    for (int i = 0; i < 5; i++) good(8'h30 + 8'(i));
    q_err++;
    send_byte(8'h77, 1'b0);
    repeat (3 * BD) @(negedge clk);
    for (int n = 0; n < 16; n++) d[16*n +: 16] = 16'hC300 + 16'(n * 16'h0101);
    frame(d);
    drain("drain_frame3");
    chk("f3_ch15", data_out[255:240], 16'hD20F);
    chk("f3_cnt", frame_cnt, 16'd3);

    @(negedge clk) rx = 1'b0;
    repeat (BD / 4) @(negedge clk);
    rx = 1'b1;
    repeat (4 * BD) @(negedge clk);
    chk("glitch_byte_data", byte_data, 8'hD2);
    chk("glitch_cnt", frame_cnt, 16'd3);

    for (int i = 0; i < 17; i++) good(8'h40 + 8'(i));
    drain("drain_17");
    exp_last = '0;
    exp_cnt = '0;
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("mid_rst_cnt", frame_cnt, 16'd0);
    chk("mid_rst_data", data_out, 256'd0);
    for (int n = 0; n < 16; n++) d[16*n +: 16] = 16'h1100 + 16'(n);
    frame(d);
    drain("drain_frame4");
    chk("f4_cnt", frame_cnt, 16'd1);
    chk("f4_ch0", data_out[15:0], 16'h1100);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
